multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, max memory-wait cycles before abort (legal 1..255).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port resetN  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port opCode  input  6  instruction opcode from the instruction register.
REQ-005 SHALL have port memReady  input  1  memory handshake; 1 = current read/write completes this cycle.
REQ-006 SHALL have outputs PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA, RegWrite, RegDst  output  1 each  datapath controls.
REQ-007 SHALL have outputs PCSource, ALUOp, ALUSrcB  output  2 each  datapath mux and ALU selects.
REQ-008 SHALL have port state  output  4  current FSM state encoding, for debug.
REQ-009 SHALL have ports illegalOp, memTimeout  output  1 each  registered single-cycle event pulses.

Function
REQ-010 SHALL use state encodings FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9; other codes SHALL go to FETCH.
REQ-011 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; and IRWrite=1, PCWrite=1 only in the cycle memReady=1.
REQ-012 FETCH SHALL stay in FETCH while memReady=0 and go to DECODE on memReady=1.
REQ-013 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00, and go to the next state in one cycle.
REQ-014 DECODE opcode dispatch: 100011/101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH, all others -> FETCH with illegalOp pulsed for one cycle.
REQ-015 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00; it goes to MEMRD on lw and to MEMWR on sw (opCode held stable by the IR).
REQ-016 MEMRD SHALL drive MemRead=1 and IorD=1, and go to MEMWB on memReady=1; otherwise it holds.
REQ-017 MEMWB SHALL drive RegWrite=1, MemtoReg=1, RegDst=0, then go to FETCH.
REQ-018 MEMWR SHALL drive MemWrite=1 and IorD=1, and go to FETCH on memReady=1; otherwise it holds.
REQ-019 EXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10, then go to ALUWB; ALUWB SHALL drive RegWrite=1, RegDst=1, MemtoReg=0, then go to FETCH.
REQ-020 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, then go to FETCH.
REQ-021 Outputs not listed for a state SHALL be 0.
REQ-022 A wait counter (8-bit) SHALL clear on entry to FETCH, MEMRD or MEMWR and increment each cycle memReady=0 while in those states.
REQ-023 When the counter reaches MEM_TIMEOUT with memReady=0, the FSM SHALL go to FETCH, pulse memTimeout for one cycle, and assert no IRWrite, PCWrite or RegWrite.
REQ-024 memReady=1 in the same cycle the counter reaches MEM_TIMEOUT SHALL complete normally; no timeout.
REQ-025 Latency SHALL be: R-type 4 cycles, lw 5, sw 4, beq 3 (with memReady=1 throughout).

Reset
REQ-026 resetN=0 SHALL immediately force state=FETCH, counter=0, illegalOp=0, memTimeout=0, and all datapath outputs to 0, regardless of clk.
REQ-027 Reset mid-instruction SHALL abandon the instruction; the first edge after release SHALL start a FETCH.

Configuration
REQ-028 With macro MULTICYCLE_JUMP_EN defined, DECODE SHALL send opcode 000010 to JUMP; JUMP SHALL drive PCWrite=1, PCSource=10, then go to FETCH (latency 3).
REQ-029 With MULTICYCLE_JUMP_EN undefined, there SHALL be no JUMP state, and opcode 000010 SHALL be illegal per REQ-014; PCSource=10 SHALL never be driven.

Verification
REQ-030 R-type 000000, memReady=1 -> states 0,1,6,7,0; RegWrite=1, RegDst=1 only in ALUWB.
REQ-031 lw 100011, memReady=0 for 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB with RegWrite=1, MemtoReg=1.
REQ-032 opcode 111111 -> DECODE then FETCH; illegalOp=1 for one cycle; no RegWrite or MemWrite asserted.
REQ-033 MEM_TIMEOUT=4, memReady stuck 0 in MEMWR -> FETCH after 4 wait cycles; memTimeout pulses once.
REQ-034 resetN driven low mid-clock in MEMRD -> state=0 and all outputs 0 without a clk edge; normal fetch after release.
REQ-035 opcode 000010: with MULTICYCLE_JUMP_EN -> states 0,1,9,0 with PCSource=10; without the macro -> illegalOp pulse.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM with bounded memory-wait timeout.
// Define MULTICYCLE_JUMP_EN to add the JUMP state (opcode 000010).
module multicycle_control #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [5:0] opCode,
  input  logic       memReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic [3:0] state,
  output logic       illegalOp,
  output logic       memTimeout
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
`ifdef MULTICYCLE_JUMP_EN
    BRANCH = 4'd8,
    JUMP   = 4'd9
`else
    BRANCH = 4'd8
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef MULTICYCLE_JUMP_EN
  localparam logic [5:0] OP_J     = 6'b000010;
`endif
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic       waiting;
  logic       timeout;
  logic       illegal_nxt;

  assign waiting = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
  // The Nth consecutive not-ready cycle aborts, unless memReady arrives in it.
  assign timeout = waiting && !memReady && (wait_cnt == WAIT_LAST);
  assign state   = state_q;

  always_comb begin
    state_nxt   = FETCH;
    illegal_nxt = 1'b0;
    case (state_q)
      FETCH:  state_nxt = memReady ? DECODE : FETCH;
      DECODE: begin
        case (opCode)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_RTYPE:     state_nxt = EXEC;
          OP_BEQ:       state_nxt = BRANCH;
`ifdef MULTICYCLE_JUMP_EN
          OP_J:         state_nxt = JUMP;
`endif
          default: begin
            state_nxt   = FETCH;
            illegal_nxt = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        if (opCode == OP_LW)      state_nxt = MEMRD;
        else if (opCode == OP_SW) state_nxt = MEMWR;
        else                      state_nxt = FETCH;
      end
      MEMRD:  state_nxt = memReady ? MEMWB : MEMRD;
      MEMWB:  state_nxt = FETCH;
      MEMWR:  state_nxt = memReady ? FETCH : MEMWR;
      EXEC:   state_nxt = ALUWB;
      ALUWB:  state_nxt = FETCH;
      BRANCH: state_nxt = FETCH;
`ifdef MULTICYCLE_JUMP_EN
      JUMP:   state_nxt = FETCH;
`endif
      default: state_nxt = FETCH;
    endcase
    if (timeout) state_nxt = FETCH;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= FETCH;
      wait_cnt   <= '0;
      illegalOp  <= 1'b0;
      memTimeout <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      illegalOp  <= illegal_nxt;
      memTimeout <= timeout;
      // Counter only survives a self-loop in a wait state; any entry starts at 0.
      wait_cnt   <= (waiting && (state_nxt == state_q) && !timeout) ? wait_cnt + 8'd1 : '0;
    end
  end

  // Datapath controls decode from state; held at 0 while reset is asserted.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcB     = 2'b00;
    if (resetN) begin
      case (state_q)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = memReady;
          PCWrite = memReady;
        end
        DECODE: ALUSrcB = 2'b11;
        MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        ALUWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
`ifdef MULTICYCLE_JUMP_EN
        JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: instruction-level trace model plus literal checks.
// Honours MULTICYCLE_JUMP_EN for the opcode 000010 scenario.
module tb_multicycle_control;

  localparam int TMO = 4;
  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                         BEQ = 6'b000100, JMP = 6'b000010, BAD = 6'b111111;

  logic       clk, resetN, memReady;
  logic [5:0] opCode;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
  logic       ALUSrcA, RegWrite, RegDst, illegalOp, memTimeout;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic [3:0] state;
  logic [15:0] dut_ctrl;

  int n_chk = 0, n_fail = 0, ill_cnt = 0, tmo_cnt = 0;
  logic [31:0] seen;
  bit chk_en, nxt_ill, nxt_tmo, exp_ill, exp_tmo;
  int exp_st;
  logic [15:0] exp_ctrl;

  multicycle_control #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .resetN(resetN), .opCode(opCode), .memReady(memReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource), .ALUOp(ALUOp),
    .ALUSrcB(ALUSrcB), .state(state), .illegalOp(illegalOp), .memTimeout(memTimeout)
  );

  assign dut_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                     ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Control word per state, listed straight from the state's control table.
  function automatic logic [15:0] ctrl_of(input int st, input bit rdy);
    bit pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, asa = 0, rw = 0, rd = 0;
    bit [1:0] pcs = 0, aop = 0, asb = 0;
    case (st)
      0: begin mrd = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      1: asb = 2'b11;
      2: begin asa = 1; asb = 2'b10; end
      3: begin mrd = 1; iord = 1; end
      4: begin rw = 1; m2r = 1; end
      5: begin mwr = 1; iord = 1; end
      6: begin asa = 1; aop = 2'b10; end
      7: begin rw = 1; rd = 1; end
      8: begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      9: begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, asa, rw, rd, pcs, aop, asb};
  endfunction

  function automatic bit rnd();
    return bit'($urandom_range(0, 1));
  endfunction

  // One clock cycle: drive memReady, publish expectations; event flags show up as pulses next cycle.
  task automatic cyc(input int st, input bit rdy, input bit ill_ev, input bit tmo_ev);
    memReady = rdy;
    exp_st   = st;
    exp_ctrl = ctrl_of(st, rdy);
    exp_ill  = nxt_ill;
    exp_tmo  = nxt_tmo;
    nxt_ill  = ill_ev;
    nxt_tmo  = tmo_ev;
    chk_en   = 1'b1;
    @(posedge clk); #1;
  endtask

  // Instruction-level trace: fw / mw are not-ready cycles in fetch / memory access.
  task automatic instr(input logic [5:0] op, input int fw, input int mw);
    int mst;
    opCode = op;
    for (int i = 0; i < fw; i++) begin
      cyc(0, 1'b0, 1'b0, i == TMO - 1);
      if (i == TMO - 1) return;
    end
    cyc(0, 1'b1, 1'b0, 1'b0);
    case (op)
      LW, SW: begin
        mst = (op == LW) ? 3 : 5;
        cyc(1, rnd(), 1'b0, 1'b0);
        cyc(2, rnd(), 1'b0, 1'b0);
        for (int i = 0; i < mw; i++) begin
          cyc(mst, 1'b0, 1'b0, i == TMO - 1);
          if (i == TMO - 1) return;
        end
        cyc(mst, 1'b1, 1'b0, 1'b0);
        if (op == LW) cyc(4, rnd(), 1'b0, 1'b0);
      end
      RT: begin
        cyc(1, rnd(), 1'b0, 1'b0);
        cyc(6, rnd(), 1'b0, 1'b0);
        cyc(7, rnd(), 1'b0, 1'b0);
      end
      BEQ: begin
        cyc(1, rnd(), 1'b0, 1'b0);
        cyc(8, rnd(), 1'b0, 1'b0);
      end
`ifdef MULTICYCLE_JUMP_EN
      JMP: begin
        cyc(1, rnd(), 1'b0, 1'b0);
        cyc(9, rnd(), 1'b0, 1'b0);
      end
`endif
      default: cyc(1, rnd(), 1'b1, 1'b0);
    endcase
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("state", state, exp_st);
        chk("ctrl", dut_ctrl, exp_ctrl);
        chk("illegalOp", illegalOp, exp_ill);
        chk("memTimeout", memTimeout, exp_tmo);
        seen = {seen[27:0], state};
        if (illegalOp) ill_cnt++;
        if (memTimeout) tmo_cnt++;
      end
    end
  end

  initial begin
    chk_en = 0; nxt_ill = 0; nxt_tmo = 0; seen = '0;
    resetN = 1'b0; opCode = RT; memReady = 1'b1;
    #3;
    chk("reset_state", state, 0);
    chk("reset_ctrl", dut_ctrl, 0);
    chk("reset_pulses", {illegalOp, memTimeout}, 0);
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;

    seen = '0; instr(RT, 0, 0);
    chk("rtype_trace", seen, 32'h0167);
    seen = '0; instr(LW, 0, 3);
    chk("lw_wait_trace", seen, 32'h01233334);
    seen = '0; instr(SW, 0, 0);
    chk("sw_trace", seen, 32'h0125);
    seen = '0; instr(BEQ, 1, 0);
    chk("beq_trace", seen, 32'h0018);

    seen = '0; instr(BAD, 0, 0);
    chk("illegal_trace", seen, 32'h01);
    instr(RT, 2, 0);
    chk("illegal_once", ill_cnt, 1);

    seen = '0; instr(SW, 0, 6);
    chk("sw_timeout_trace", seen, 32'h0125555);
    instr(BEQ, 0, 0);
    chk("tmo_once", tmo_cnt, 1);
    instr(RT, 5, 0);
    instr(SW, 0, 1);
    chk("fetch_tmo", tmo_cnt, 2);
    instr(LW, 0, 4);
    instr(RT, 0, 0);
    chk("lw_tmo", tmo_cnt, 3);

    seen = '0; instr(JMP, 0, 0);
`ifdef MULTICYCLE_JUMP_EN
    chk("jump_trace", seen, 32'h019);
    instr(RT, 0, 0);
    chk("jump_no_illegal", ill_cnt, 1);
`else
    chk("jump_trace", seen, 32'h01);
    instr(RT, 0, 0);
    chk("jump_illegal", ill_cnt, 2);
`endif

    // Asynchronous reset in the middle of a MEMRD wait.
    opCode = LW;
    cyc(0, 1'b1, 1'b0, 1'b0);
    cyc(1, 1'b1, 1'b0, 1'b0);
    cyc(2, 1'b1, 1'b0, 1'b0);
    chk_en = 1'b0;
    memReady = 1'b0;
    #2 resetN = 1'b0;
    #1;
    chk("midrst_state", state, 0);
    chk("midrst_ctrl", dut_ctrl, 0);
    chk("midrst_pulses", {illegalOp, memTimeout}, 0);
    @(posedge clk); #1;
    chk("midrst_hold", state, 0);
    resetN = 1'b1;
    nxt_ill = 0; nxt_tmo = 0;
    seen = '0; instr(LW, 0, 0);
    chk("post_reset_lw", seen, 32'h01234);
    instr(RT, 0, 0);

    chk_en = 1'b0;
    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
